// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the multi-lane bus arbiter.
// Lane state encoding, destination extraction and rotating pick.
package bus_arb_pkg;

    localparam int MAX_DRVRS = 16;
    localparam int MAX_PKT   = 256;
    localparam int PTR_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DECODE,
        DELIVER
    } lane_state_e;

    // Destination ID sits in the top byte of the packet.
    function automatic logic [7:0] dest_of(
        input logic [MAX_PKT-1:0] pckg,
        input int                 width
    );
        return pckg[width-1 -: 8];
    endfunction

    // First requester at or after ptr, wrapping at n.
    // Wrap is an explicit compare so n need not be a power of two.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [MAX_DRVRS-1:0] req,
        input logic [PTR_W-1:0]     ptr,
        input int                   n
    );
        logic [PTR_W-1:0] win;
        logic             found;
        logic [PTR_W:0]   idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_DRVRS; i++) begin
            idx = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (idx >= (PTR_W + 1)'(n)) begin
                idx = idx - (PTR_W + 1)'(n);
            end
            if (!found && (i < n) && req[idx[PTR_W-1:0]]) begin
                win   = idx[PTR_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_mb_lane.sv
// One bus lane: arbitration FSM, packet register,
// round-robin pointer and saturating delivered-packet counter.
module bus_lane_arb
    import bus_arb_pkg::*;
#(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF,
    parameter int         rr_mode   = 1,
    parameter int         cnt_w     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   d_pop,
    output logic [drvrs-1:0]           pop,
    input  logic [drvrs-1:0]           full,
    output logic [drvrs-1:0]           push,
    output logic [pckg_sz-1:0]         d_push,
    output logic                       drop,
    output logic [cnt_w-1:0]           pkt_cnt
);

    localparam int IW = $clog2(drvrs);

    lane_state_e          state_q;
    lane_state_e          state_d;
    logic [IW-1:0]        win_q;
    logic [IW-1:0]        win_d;
    logic [IW-1:0]        src_q;
    logic [IW-1:0]        ptr_q;
    logic [pckg_sz-1:0]   pkt_q;
    logic [drvrs-1:0]     mask_q;
    logic [drvrs-1:0]     mask_d;
    logic [7:0]           dest;
    logic                 stall;

    assign stall = |(mask_q & full);

    // State, winner, target mask, packet, pointer and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            pkt_q   <= '0;
            mask_q  <= '0;
            pkt_cnt <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            mask_q  <= mask_d;
            if (state_q == GRANT) begin
                pkt_q <= d_pop[win_q*pckg_sz +: pckg_sz];
                src_q <= win_q;
                ptr_q <= (win_q == IW'(drvrs - 1)) ? '0 : win_q + IW'(1);
            end
            if (state_q == DELIVER && !stall && pkt_cnt != '1) begin
                pkt_cnt <= pkt_cnt + cnt_w'(1);
            end
        end
    end

    // Next-state and strobe outputs; outputs follow state so reset clears them at once.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        mask_d  = mask_q;
        pop     = '0;
        push    = '0;
        drop    = 1'b0;
        d_push  = '0;
        dest    = dest_of(MAX_PKT'(pkt_q), pckg_sz);
        unique case (state_q)
            IDLE: begin
                if (|pndng) begin
                    win_d = IW'(rr_pick(MAX_DRVRS'(pndng),
                                        (rr_mode != 0) ? PTR_W'(ptr_q) : '0,
                                        drvrs));
                    state_d = GRANT;
                end
            end
            GRANT: begin
                pop[win_q] = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                if (dest == broadcast) begin
                    mask_d        = '1;
                    mask_d[src_q] = 1'b0;
                    state_d       = DELIVER;
                end else if (int'(dest) < drvrs) begin
                    mask_d                = '0;
                    mask_d[dest[IW-1:0]]  = 1'b1;
                    state_d               = DELIVER;
                end else begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end
            end
            DELIVER: begin
                d_push = pkt_q;
                if (!stall) begin
                    push    = mask_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/bus_rr_arbiter_mb.sv
// Multi-lane bus generator/arbiter top level.
// Replicates one independent lane arbiter per bus lane.
module bus_rr_arbiter_mb #(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF,
    parameter int         rr_mode   = 1,
    parameter int         cnt_w     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [bits*drvrs-1:0]           pndng,
    input  logic [bits*drvrs*pckg_sz-1:0]   D_pop,
    output logic [bits*drvrs-1:0]           pop,
    input  logic [bits*drvrs-1:0]           full,
    output logic [bits*drvrs-1:0]           push,
    output logic [bits*pckg_sz-1:0]         D_push,
    output logic [bits-1:0]                 drop,
    output logic [bits*cnt_w-1:0]           pkt_cnt
);

    for (genvar l = 0; l < bits; l++) begin : g_lane
        bus_lane_arb #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast),
            .rr_mode   (rr_mode),
            .cnt_w     (cnt_w)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .pndng   (pndng[l*drvrs +: drvrs]),
            .d_pop   (D_pop[l*drvrs*pckg_sz +: drvrs*pckg_sz]),
            .pop     (pop[l*drvrs +: drvrs]),
            .full    (full[l*drvrs +: drvrs]),
            .push    (push[l*drvrs +: drvrs]),
            .d_push  (D_push[l*pckg_sz +: pckg_sz]),
            .drop    (drop[l]),
            .pkt_cnt (pkt_cnt[l*cnt_w +: cnt_w])
        );
    end

endmodule

// File: tb/tb_bus_rr_arbiter_mb.sv
// Bench for bus_rr_arbiter_mb: two-lane round-robin instance plus
// a one-lane fixed-priority instance, checked against a timeline model.
module tb_bus_rr_arbiter_mb;

    localparam int D     = 4;
    localparam int W     = 16;
    localparam int CW    = 16;
    localparam int NL    = 3;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NL*D-1:0]   pn;
    logic [NL*D-1:0]   fl;
    logic [NL*D*W-1:0] dp;

    logic [2*D-1:0]  a_pop, a_push;
    logic [D-1:0]    b_pop, b_push;
    logic [2*W-1:0]  a_dpush;
    logic [W-1:0]    b_dpush;
    logic [1:0]      a_drop;
    logic            b_drop;
    logic [2*CW-1:0] a_cnt;
    logic [CW-1:0]   b_cnt;

    logic [NL*D-1:0]  popv, pushv;
    logic [NL*W-1:0]  dpushv;
    logic [NL*CW-1:0] cntv;
    logic [NL-1:0]    dropv;

    assign popv   = {b_pop, a_pop};
    assign pushv  = {b_push, a_push};
    assign dpushv = {b_dpush, a_dpush};
    assign cntv   = {b_cnt, a_cnt};
    assign dropv  = {b_drop, a_drop};

    bus_rr_arbiter_mb #(
        .bits(2), .drvrs(D), .pckg_sz(W),
        .broadcast(8'hFF), .rr_mode(1), .cnt_w(CW)
    ) dut_a (
        .clk(clk), .reset(reset),
        .pndng(pn[2*D-1:0]), .D_pop(dp[2*D*W-1:0]),
        .pop(a_pop), .full(fl[2*D-1:0]), .push(a_push),
        .D_push(a_dpush), .drop(a_drop), .pkt_cnt(a_cnt)
    );

    bus_rr_arbiter_mb #(
        .bits(1), .drvrs(D), .pckg_sz(W),
        .broadcast(8'hFF), .rr_mode(0), .cnt_w(CW)
    ) dut_b (
        .clk(clk), .reset(reset),
        .pndng(pn[3*D-1:2*D]), .D_pop(dp[3*D*W-1:2*D*W]),
        .pop(b_pop), .full(fl[3*D-1:2*D]), .push(b_push),
        .D_push(b_dpush), .drop(b_drop), .pkt_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Driver FIFOs: written by stimulus, dequeued by the model.
    bit [W-1:0] mem [NL][D][DEPTH];
    int wr [NL][D];
    int rd [NL][D];

    always_comb begin
        pn = '0;
        dp = '0;
        for (int l = 0; l < NL; l++) begin
            for (int p = 0; p < D; p++) begin
                pn[l*D+p] = (wr[l][p] != rd[l][p]);
                dp[(l*D+p)*W +: W] = mem[l][p][rd[l][p] % DEPTH];
            end
        end
    end

    task automatic push_pkt(input int l, input int p, input bit [W-1:0] d);
        mem[l][p][wr[l][p] % DEPTH] = d;
        wr[l][p] = wr[l][p] + 1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] req, input int start);
        for (int i = 0; i < D; i++) begin
            if (req[(start + i) % D]) return (start + i) % D;
        end
        return 0;
    endfunction

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < D; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Per-lane timeline: t=1 pop, t=2 destination decision, t>=3 delivery.
    bit         m_busy [NL];
    int         m_t    [NL];
    int         m_win  [NL];
    int         m_ptr  [NL];
    bit [W-1:0] m_pkt  [NL];
    bit [3:0]   m_mask [NL];
    bit         m_inv  [NL];
    int         m_cnt  [NL];

    always @(posedge clk or negedge reset) begin : model
        logic [3:0] req;
        logic [7:0] dst;
        if (!reset) begin
            for (int l = 0; l < NL; l++) begin
                m_busy[l] = 1'b0;
                m_t[l]    = 0;
                m_ptr[l]  = 0;
                m_cnt[l]  = 0;
                for (int p = 0; p < D; p++) rd[l][p] <= wr[l][p];
            end
        end else begin
            for (int l = 0; l < NL; l++) begin
                req = pn[l*D +: D];
                if (!m_busy[l]) begin
                    if (req != 0) begin
                        m_win[l]  = pick(req, (l < 2) ? m_ptr[l] : 0);
                        m_ptr[l]  = (m_win[l] + 1) % D;
                        m_busy[l] = 1'b1;
                        m_t[l]    = 1;
                    end
                end else if (m_t[l] == 1) begin
                    m_pkt[l] = dp[(l*D + m_win[l])*W +: W];
                    rd[l][m_win[l]] <= rd[l][m_win[l]] + 1;
                    dst = m_pkt[l][W-1 -: 8];
                    m_inv[l] = 1'b0;
                    if (dst == 8'hFF) m_mask[l] = 4'hF & ~(4'b1 << m_win[l]);
                    else if (dst < D) m_mask[l] = 4'b1 << dst;
                    else begin
                        m_mask[l] = 4'h0;
                        m_inv[l]  = 1'b1;
                    end
                    m_t[l] = 2;
                end else if (m_t[l] == 2) begin
                    if (m_inv[l]) m_busy[l] = 1'b0;
                    else m_t[l] = 3;
                end else if ((m_mask[l] & fl[l*D +: D]) == 0) begin
                    if (m_cnt[l] < 65535) m_cnt[l]++;
                    m_busy[l] = 1'b0;
                end
            end
        end
    end

    // Compare every lane against the model on each falling edge.
    always @(negedge clk) begin : cmp
        logic [3:0]   ep, eu;
        logic         ed;
        logic [W-1:0] edp;
        for (int l = 0; l < NL; l++) begin
            ep  = (m_busy[l] && m_t[l] == 1) ? 4'(1 << m_win[l]) : 4'h0;
            eu  = (m_busy[l] && m_t[l] == 3 &&
                   (m_mask[l] & fl[l*D +: D]) == 0) ? m_mask[l] : 4'h0;
            ed  = m_busy[l] && m_t[l] == 2 && m_inv[l];
            edp = (m_busy[l] && m_t[l] == 3) ? m_pkt[l] : '0;
            chk($sformatf("pop l%0d", l), 32'(popv[l*D +: D]), 32'(ep));
            chk($sformatf("push l%0d", l), 32'(pushv[l*D +: D]), 32'(eu));
            chk($sformatf("drop l%0d", l), 32'(dropv[l]), 32'(ed));
            chk($sformatf("dpush l%0d", l), 32'(dpushv[l*W +: W]), 32'(edp));
            chk($sformatf("cnt l%0d", l), 32'(cntv[l*CW +: CW]), 32'(m_cnt[l]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin : stim
        int ord [8];
        int oc  [8];
        int n;
        int exp_rr [5];
        int exp_fp [5];
        exp_rr = '{0, 1, 2, 3, 0};
        exp_fp = '{1, 1, 1, 3, 3};
        fl = '0;
        #1 reset = 1'b0;
        #1;
        chk("reset pop", 32'(popv), 0);
        chk("reset push", 32'(pushv), 0);
        chk("reset dpush", 32'(|dpushv), 0);
        chk("reset cnt", 32'(|cntv), 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // single packet lane 0: port 1 -> port 2
        push_pkt(0, 1, 16'h0255);
        neg();
        chk("single idle pop", 32'(popv[3:0]), 32'h0);
        neg();
        chk("single pop", 32'(popv[3:0]), 32'h2);
        neg();
        chk("single decode push", 32'(pushv[3:0]), 32'h0);
        neg();
        chk("single push", 32'(pushv[3:0]), 32'h4);
        chk("single dpush", 32'(dpushv[15:0]), 32'h0255);
        neg();
        chk("single cnt", 32'(cntv[15:0]), 32'd1);

        // round-robin fairness on lane 1
        tick();
        for (int p = 0; p < D; p++) begin
            for (int k = 0; k < 2; k++) push_pkt(1, p, {8'h00, 4'(p), 4'(k)});
        end
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            neg();
            if (popv[7:4] != 0) begin
                ord[n] = oh2i(popv[7:4]);
                oc[n]  = cyc;
                n++;
            end
        end
        chk("rr grants", n, 5);
        for (int i = 0; i < n; i++) chk("rr order", ord[i], exp_rr[i]);
        for (int i = 1; i < n; i++) chk("rr gap", oc[i] - oc[i-1], 4);
        repeat (20) neg();
        chk("rr cnt", 32'(cntv[31:16]), 32'd8);

        // fixed priority on the single-lane instance
        tick();
        push_pkt(2, 1, 16'h0211);
        push_pkt(2, 1, 16'h0212);
        push_pkt(2, 1, 16'h0213);
        push_pkt(2, 3, 16'h0033);
        push_pkt(2, 3, 16'h0034);
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            neg();
            if (popv[11:8] != 0) begin
                ord[n] = oh2i(popv[11:8]);
                n++;
            end
        end
        chk("fp grants", n, 5);
        for (int i = 0; i < n; i++) chk("fp order", ord[i], exp_fp[i]);
        repeat (8) neg();
        chk("fp cnt", 32'(cntv[47:32]), 32'd5);

        // broadcast from port 2 with port 0 full
        tick();
        fl[0] = 1'b1;
        push_pkt(0, 2, 16'hFF12);
        neg();
        for (int c = 0; c < 5; c++) begin
            neg();
            chk("bcast stall push", 32'(pushv[3:0]), 32'h0);
        end
        tick();
        fl[0] = 1'b0;
        neg();
        chk("bcast push", 32'(pushv[3:0]), 32'hB);
        chk("bcast dpush", 32'(dpushv[15:0]), 32'hFF12);
        neg();
        chk("bcast push once", 32'(pushv[3:0]), 32'h0);
        chk("bcast cnt", 32'(cntv[15:0]), 32'd2);

        // invalid destination, then next pending port
        tick();
        push_pkt(0, 0, 16'h07AA);
        neg();
        tick();
        push_pkt(0, 3, 16'h0133);
        neg();
        chk("inv pop", 32'(popv[3:0]), 32'h1);
        neg();
        chk("inv drop", 32'(dropv[0]), 32'h1);
        chk("inv push", 32'(pushv[3:0]), 32'h0);
        neg();
        chk("inv drop once", 32'(dropv[0]), 32'h0);
        chk("inv cnt", 32'(cntv[15:0]), 32'd2);
        neg();
        chk("next pop", 32'(popv[3:0]), 32'h8);
        neg();
        neg();
        chk("next push", 32'(pushv[3:0]), 32'h2);
        chk("next dpush", 32'(dpushv[15:0]), 32'h0133);
        neg();
        chk("next cnt", 32'(cntv[15:0]), 32'd3);

        // lane 0 stalls, lane 1 delivers, then async reset mid-stall
        tick();
        fl[1] = 1'b1;
        push_pkt(0, 0, 16'h0101);
        push_pkt(1, 2, 16'h0333);
        neg();
        neg();
        chk("ml pop l0", 32'(popv[3:0]), 32'h1);
        chk("ml pop l1", 32'(popv[7:4]), 32'h4);
        neg();
        neg();
        chk("ml push l1", 32'(pushv[7:4]), 32'h8);
        chk("ml stall l0", 32'(pushv[3:0]), 32'h0);
        chk("ml hold l0", 32'(dpushv[15:0]), 32'h0101);
        neg();
        chk("ml cnt l1", 32'(cntv[31:16]), 32'd9);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst push", 32'(pushv), 0);
        chk("arst pop", 32'(popv), 0);
        chk("arst dpush", 32'(|dpushv), 0);
        chk("arst cnt", 32'(|cntv), 0);
        tick();
        tick();
        fl = '0;
        tick();
        reset = 1'b1;
        repeat (6) neg();
        chk("post rst cnt", 32'(|cntv), 0);
        chk("post rst push", 32'(pushv), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
